// File: rtl/stack_cpu_v2.sv
// stack_cpu_v2: two-cycle (FETCH/EXEC) stack machine with signed ALU, branches and
// sticky HALTED/FAULT states; a fault leaves stack, depth and pc untouched.
module stack_cpu_v2 #(
   parameter int DATA_WIDTH  = 32,
   parameter int STACK_DEPTH = 16,
   parameter int IMM_WIDTH   = 10,
   parameter int PC_WIDTH    = 10,
   localparam int INSTR_WIDTH = 4 + IMM_WIDTH,
   localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [INSTR_WIDTH-1:0]       instruction,
   output logic [PC_WIDTH-1:0]          pc,
   output logic signed [DATA_WIDTH-1:0] result,
   output logic [DEPTH_W-1:0]           depth,
   output logic                         halt,
   output logic                         error,
   output logic [1:0]                   error_code
);
   localparam int AW = $clog2(STACK_DEPTH);
   localparam logic [1:0] FETCH = 2'd0, EXEC = 2'd1, HALTED = 2'd2, FAULT = 2'd3;
   logic [1:0] state;
   logic [INSTR_WIDTH-1:0] ir;
   logic [DATA_WIDTH-1:0] stk [STACK_DEPTH];
   logic [3:0] op;
   logic [IMM_WIDTH-1:0] imm;
   logic [AW-1:0] t_idx, n_idx, w_idx;
   logic [DATA_WIDTH-1:0] a, b, alu, quot, rem;
   logic [DEPTH_W-1:0] need, nsp;
   logic [PC_WIDTH-1:0] npc;
   logic [1:0] ecode;
   assign op = ir[INSTR_WIDTH-1 -: 4];
   assign imm = ir[IMM_WIDTH-1:0];
   assign t_idx = AW'(depth - DEPTH_W'(1));
   assign n_idx = AW'(depth - DEPTH_W'(2));
   assign a = stk[n_idx];
   assign b = stk[t_idx];
   always_comb begin
      quot = '0;
      rem = '0;
      // divisor -1 is negation; this also wraps most-negative back onto itself
      if (b == '1) quot = '0 - a;
      else if (b != '0) begin
         quot = $signed(a) / $signed(b);
         rem = $signed(a) % $signed(b);
      end
   end
   always_comb begin
      alu = b;
      case (op)
         4'd0: alu = DATA_WIDTH'($signed(imm));
         4'd1: alu = a + b;
         4'd2: alu = a - b;
         4'd3: alu = a * b;
         4'd4: alu = quot;
         4'd5: alu = rem;
         4'd6: alu = a & b;
         4'd7: alu = a | b;
         4'd8: alu = ~b;
         default: alu = b;
      endcase
   end
   assign need = op inside {[4'd1:4'd7], 4'd10} ? DEPTH_W'(2) : op inside {[4'd8:4'd12]} ? DEPTH_W'(1) : DEPTH_W'(0);
   assign ecode = depth < need ? 2'd1 :
                  (op == 4'd0 || op == 4'd9) && depth == DEPTH_W'(STACK_DEPTH) ? 2'd2 :
                  (op == 4'd4 || op == 4'd5) && b == '0 ? 2'd3 : 2'd0;
   assign nsp = (op == 4'd0 || op == 4'd9) ? depth + DEPTH_W'(1) :
                op inside {[4'd1:4'd7], 4'd11, 4'd12} ? depth - DEPTH_W'(1) : depth;
   assign npc = op == 4'd13 || (op == 4'd12 && b == '0) ? PC_WIDTH'(imm) : pc + PC_WIDTH'(1);
   assign w_idx = op inside {[4'd1:4'd7]} ? n_idx : op == 4'd8 ? t_idx : AW'(depth);
   always_ff @(posedge clk) begin
      if (state == EXEC && ecode == 2'd0) begin
         if (op inside {[4'd0:4'd9]}) stk[w_idx] <= alu;
         if (op == 4'd10) begin
            stk[t_idx] <= a;
            stk[n_idx] <= b;
         end
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= FETCH;
         ir <= '0;
         pc <= '0;
         depth <= '0;
         error_code <= 2'd0;
      end else if (state == FETCH) begin
         ir <= instruction;
         state <= EXEC;
      end else if (state == EXEC) begin
         if (ecode != 2'd0) begin
            error_code <= ecode;
            state <= FAULT;
         end else if (op == 4'd15) state <= HALTED;
         else begin
            pc <= npc;
            depth <= nsp;
            state <= FETCH;
         end
      end
   end
   assign halt = state == HALTED || state == FAULT;
   assign error = state == FAULT;
   assign result = depth == '0 ? '0 : stk[t_idx];
endmodule

// File: tb/tb_stack_cpu_v2.sv
// tb_stack_cpu_v2: table-driven programs with hand-computed end states, plus
// hand sequences for exact timing, overflow, pc wrap and mid-instruction reset.
module tb_stack_cpu_v2;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [13:0] instruction;
   logic [9:0] pc;
   logic signed [31:0] result;
   logic [4:0] depth;
   logic halt, error;
   logic [1:0] error_code;
   logic [13:0] mem [1024];
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   assign instruction = mem[pc];
   stack_cpu_v2 dut (
      .clk(clk), .reset(reset), .instruction(instruction), .pc(pc), .result(result),
      .depth(depth), .halt(halt), .error(error), .error_code(error_code)
   );
   typedef struct {
      string name;
      int start;
      int len;
      logic [31:0] res;
      int dep;
      int pcv;
      logic err;
      logic [1:0] ec;
   } vec_t;
   vec_t vecs[$];
   logic [13:0] pool[$];
   int vstart = 0;
   function automatic logic [13:0] ins(input logic [3:0] op, input int imm);
      logic [31:0] v;
      v = imm;
      return {op, v[9:0]};
   endfunction
   task automatic prg(input logic [3:0] op, input int imm = 0);
      pool.push_back(ins(op, imm));
   endtask
   task automatic expect_vec(input string name, input logic [31:0] res, input int dep, input int pcv,
                             input logic err, input logic [1:0] ec);
      vec_t v;
      v.name = name;
      v.start = vstart;
      v.len = pool.size() - vstart;
      v.res = res;
      v.dep = dep;
      v.pcv = pcv;
      v.err = err;
      v.ec = ec;
      vecs.push_back(v);
      vstart = pool.size();
   endtask
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic clear_mem();
      for (int i = 0; i < 1024; i++) mem[i] = ins(15, 0);
   endtask
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask
   task automatic run(input string name);
      int n;
      n = 0;
      while (!halt && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!halt) begin
         checks++;
         errors++;
         $display("FAIL %s: timeout, halt=%0b expected 1", name, halt);
      end
   endtask
   task automatic check_all(input string name, input logic [31:0] res, input int dep, input int pcv,
                            input logic hlt, input logic err, input logic [1:0] ec);
      check({name, ".result"}, result, res);
      check({name, ".depth"}, 32'(depth), dep);
      check({name, ".pc"}, 32'(pc), pcv);
      check({name, ".halt"}, 32'(halt), 32'(hlt));
      check({name, ".error"}, 32'(error), 32'(err));
      check({name, ".error_code"}, 32'(error_code), 32'(ec));
   endtask
   initial begin
      clear_mem();
      #12;
      check_all("reset", 0, 0, 0, 0, 0, 0);
      prg(0, 7); prg(0, 3); prg(2); prg(15);
      expect_vec("sub", 4, 1, 3, 0, 0);
      prg(0, -7); prg(0, 2); prg(4); prg(15);
      expect_vec("div", 32'hFFFF_FFFD, 1, 3, 0, 0);
      prg(0, -7); prg(0, 2); prg(5); prg(15);
      expect_vec("mod", 32'hFFFF_FFFF, 1, 3, 0, 0);
      prg(1);
      expect_vec("add_empty", 0, 0, 0, 1, 1);
      prg(0, 5); prg(0, 0); prg(4);
      expect_vec("div_zero", 0, 2, 2, 1, 3);
      prg(0, -7); prg(0, 0); prg(5);
      expect_vec("mod_zero", 0, 2, 2, 1, 3);
      prg(0, 3); prg(9); prg(12, 9); prg(0, -1); prg(1); prg(9); prg(12, 8); prg(13, 1); prg(15);
      expect_vec("loop", 0, 1, 8, 0, 0);
      prg(0, -3); prg(0, 5); prg(3); prg(15);
      expect_vec("mul", 32'hFFFF_FFF1, 1, 3, 0, 0);
      prg(0, 12); prg(0, 10); prg(6); prg(0, 3); prg(7); prg(15);
      expect_vec("and_or", 11, 1, 5, 0, 0);
      prg(0, 5); prg(8); prg(15);
      expect_vec("invert", 32'hFFFF_FFFA, 1, 2, 0, 0);
      prg(0, 1); prg(0, 2); prg(10); prg(11); prg(15);
      expect_vec("swap_drop", 2, 1, 4, 0, 0);
      prg(0, -512); prg(0, -512); prg(3); prg(0, -512); prg(3); prg(0, 16); prg(3); prg(0, -1); prg(4); prg(15);
      expect_vec("minneg_div", 32'h8000_0000, 1, 9, 0, 0);
      prg(0, -512); prg(0, -512); prg(3); prg(0, -512); prg(3); prg(0, 16); prg(3); prg(0, -1); prg(5); prg(15);
      expect_vec("minneg_mod", 0, 1, 9, 0, 0);
      prg(0, -512); prg(0, -512); prg(3); prg(0, -512); prg(3); prg(0, 16); prg(3); prg(0, 1); prg(2); prg(15);
      expect_vec("wrap_sub", 32'h7FFF_FFFF, 1, 9, 0, 0);
      prg(0, 4); prg(10);
      expect_vec("swap_under", 4, 1, 1, 1, 1);
      prg(12, 3);
      expect_vec("jz_under", 0, 0, 0, 1, 1);
      prg(0, 2); prg(12, 5); prg(15);
      expect_vec("jz_fall", 0, 0, 2, 0, 0);
      foreach (vecs[k]) begin
         clear_mem();
         for (int i = 0; i < vecs[k].len; i++) mem[i] = pool[vecs[k].start + i];
         do_reset();
         run(vecs[k].name);
         check_all(vecs[k].name, vecs[k].res, vecs[k].dep, vecs[k].pcv, 1'b1, vecs[k].err, vecs[k].ec);
      end
      clear_mem();
      mem[0] = ins(0, 7); mem[1] = ins(0, 3); mem[2] = ins(2, 0);
      do_reset();
      repeat (7) @(posedge clk);
      #1;
      check("timing.halt_c7", 32'(halt), 0);
      check("timing.pc_c7", 32'(pc), 3);
      @(posedge clk);
      #1;
      check_all("timing_c8", 4, 1, 3, 1, 0, 0);
      @(negedge clk);
      mem[3] = ins(0, 1);
      repeat (4) @(posedge clk);
      #1;
      check_all("halted_sticky", 4, 1, 3, 1, 0, 0);
      for (int k = 0; k < 2; k++) begin
         clear_mem();
         for (int i = 0; i < 17; i++) mem[i] = ins(0, 1);
         if (k == 1) mem[16] = ins(9, 0);
         do_reset();
         run("overflow");
         check_all(k == 0 ? "overflow_pushi" : "overflow_dup", 1, 16, 16, 1, 1, 2);
      end
      clear_mem();
      mem[0] = ins(13, 1023);
      mem[1023] = ins(0, 6);
      do_reset();
      repeat (4) @(posedge clk);
      #1;
      check_all("pc_wrap", 6, 1, 0, 0, 0, 0);
      clear_mem();
      mem[0] = ins(0, 9); mem[1] = ins(0, 8); mem[2] = ins(1, 0);
      do_reset();
      repeat (3) @(posedge clk);
      #1;
      check("midreset.pre_depth", 32'(depth), 1);
      #2;
      reset = 1'b0;
      #1;
      check_all("midreset_async", 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      run("midreset_rerun");
      check_all("midreset_rerun", 17, 1, 3, 1, 0, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
